// File: rtl/csr_trap_seq_pkg.sv
// Shared definitions for the machine-mode trap/mret CSR sequencer:
// CSR addresses, mstatus bit positions, CSR op encodings and FSM states.
package csr_trap_seq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] CSR_OP_NOP = 2'd0;
  localparam logic [1:0] CSR_OP_RW  = 2'd1;
  localparam logic [1:0] CSR_OP_RS  = 2'd2;
  localparam logic [1:0] CSR_OP_RC  = 2'd3;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    T_EPC   = 4'd1,
    T_CAUSE = 4'd2,
    T_TVAL  = 4'd3,
    T_ST_RD = 4'd4,
    T_ST_WR = 4'd5,
    T_VEC   = 4'd6,
    T_DONE  = 4'd7,
    M_ST_RD = 4'd8,
    M_ST_WR = 4'd9,
    M_EPC   = 4'd10,
    M_DONE  = 4'd11
  } seq_state_e;

endpackage

// File: rtl/csr_trap_seq_port_mux.sv
// Selects whether the pipeline or the trap/mret sequencer drives the
// shared CSR port. Purely combinational so pipeline accesses add no latency.
module csr_port_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              i_sel_pipe,
  input  logic              i_pipe_rd,
  input  logic [1:0]        i_pipe_wr_op,
  input  logic [ADDR_W-1:0] i_pipe_addr,
  input  logic [DATA_W-1:0] i_pipe_wdata,
  input  logic              i_seq_rd,
  input  logic [1:0]        i_seq_wr_op,
  input  logic [ADDR_W-1:0] i_seq_addr,
  input  logic [DATA_W-1:0] i_seq_wdata,
  output logic              o_csr_rd,
  output logic [1:0]        o_csr_wr_op,
  output logic [ADDR_W-1:0] o_csr_addr,
  output logic [DATA_W-1:0] o_csr_wdata
);

  always_comb begin
    if (i_sel_pipe) begin
      o_csr_rd    = i_pipe_rd;
      o_csr_wr_op = i_pipe_wr_op;
      o_csr_addr  = i_pipe_addr;
      o_csr_wdata = i_pipe_wdata;
    end else begin
      o_csr_rd    = i_seq_rd;
      o_csr_wr_op = i_seq_wr_op;
      o_csr_addr  = i_seq_addr;
      o_csr_wdata = i_seq_wdata;
    end
  end

endmodule

// File: rtl/csr_trap_seq.sv
// Machine-mode trap entry / mret sequencer that walks the CSR updates one
// per cycle over the shared CSR port, stalling the pipeline meanwhile.
module csr_trap_seq
  import csr_trap_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_csr_rd,
  input  logic [1:0]        pipe_csr_wr_op,
  input  logic [ADDR_W-1:0] pipe_csr_addr,
  input  logic [DATA_W-1:0] pipe_csr_wdata,
  output logic              pipe_stall,
  input  logic              trap_req,
  input  logic [DATA_W-1:0] trap_cause,
  input  logic [DATA_W-1:0] trap_pc,
  input  logic [DATA_W-1:0] trap_tval,
  input  logic              mret_req,
  output logic              trap_done,
  output logic [DATA_W-1:0] trap_target,
  output logic              mret_done,
  output logic [DATA_W-1:0] mret_target,
  output logic              csr_rd,
  output logic [1:0]        csr_wr_op,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic [DATA_W-1:0] csr_rdata
);

  localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(CSR_MSTATUS);
  localparam logic [ADDR_W-1:0] A_MTVEC   = ADDR_W'(CSR_MTVEC);
  localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(CSR_MEPC);
  localparam logic [ADDR_W-1:0] A_MCAUSE  = ADDR_W'(CSR_MCAUSE);
  localparam logic [ADDR_W-1:0] A_MTVAL   = ADDR_W'(CSR_MTVAL);

  seq_state_e        r_state, w_state_next;
  logic [DATA_W-1:0] r_mstatus;
  logic [DATA_W-1:0] r_trap_target;
  logic [DATA_W-1:0] r_mret_target;
  logic              r_trap_done;
  logic              r_mret_done;

  logic              w_sel_pipe;
  logic              w_stall;
  logic              w_seq_rd;
  logic [1:0]        w_seq_wr_op;
  logic [ADDR_W-1:0] w_seq_addr;
  logic [DATA_W-1:0] w_seq_wdata;
  logic [DATA_W-1:0] w_mstatus_trap;
  logic [DATA_W-1:0] w_mstatus_mret;
  logic [DATA_W-1:0] w_vec_base;
  logic [DATA_W-1:0] w_vec_off;
  logic              w_vectored;
  logic [DATA_W-1:0] w_trap_target;
  logic              w_unused;

  always_comb begin
    w_mstatus_trap = r_mstatus;
    w_mstatus_trap[MSTATUS_MPIE] = r_mstatus[MSTATUS_MIE];
    w_mstatus_trap[MSTATUS_MIE]  = 1'b0;
    w_mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    w_mstatus_mret = r_mstatus;
    w_mstatus_mret[MSTATUS_MIE]  = r_mstatus[MSTATUS_MPIE];
    w_mstatus_mret[MSTATUS_MPIE] = 1'b1;
    w_mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // 4*cause mod 2^DATA_W only needs the low DATA_W-2 cause bits.
  assign w_vec_base    = {csr_rdata[DATA_W-1:2], 2'b00};
  assign w_vec_off     = {trap_cause[DATA_W-3:0], 2'b00};
  assign w_vectored    = (csr_rdata[1:0] == 2'b01) && trap_cause[DATA_W-1];
  assign w_trap_target = w_vectored ? (w_vec_base + w_vec_off) : w_vec_base;
  assign w_unused      = trap_cause[DATA_W-2];

  always_comb begin
    w_state_next = r_state;
    w_sel_pipe   = 1'b0;
    w_stall      = 1'b1;
    w_seq_rd     = 1'b0;
    w_seq_wr_op  = CSR_OP_NOP;
    w_seq_addr   = '0;
    w_seq_wdata  = '0;
    case (r_state)
      IDLE: begin
        if (trap_req) begin
          w_state_next = T_EPC;
        end else if (mret_req) begin
          w_state_next = M_ST_RD;
        end else begin
          w_sel_pipe = 1'b1;
          w_stall    = 1'b0;
        end
      end
      T_EPC: begin
        w_seq_wr_op  = CSR_OP_RW;
        w_seq_addr   = A_MEPC;
        w_seq_wdata  = trap_pc;
        w_state_next = T_CAUSE;
      end
      T_CAUSE: begin
        w_seq_wr_op  = CSR_OP_RW;
        w_seq_addr   = A_MCAUSE;
        w_seq_wdata  = trap_cause;
        w_state_next = T_TVAL;
      end
      T_TVAL: begin
        w_seq_wr_op  = CSR_OP_RW;
        w_seq_addr   = A_MTVAL;
        w_seq_wdata  = trap_tval;
        w_state_next = T_ST_RD;
      end
      T_ST_RD: begin
        w_seq_rd     = 1'b1;
        w_seq_addr   = A_MSTATUS;
        w_state_next = T_ST_WR;
      end
      T_ST_WR: begin
        w_seq_wr_op  = CSR_OP_RW;
        w_seq_addr   = A_MSTATUS;
        w_seq_wdata  = w_mstatus_trap;
        w_state_next = T_VEC;
      end
      T_VEC: begin
        w_seq_rd     = 1'b1;
        w_seq_addr   = A_MTVEC;
        w_state_next = T_DONE;
      end
      T_DONE:  w_state_next = IDLE;
      M_ST_RD: begin
        w_seq_rd     = 1'b1;
        w_seq_addr   = A_MSTATUS;
        w_state_next = M_ST_WR;
      end
      M_ST_WR: begin
        w_seq_wr_op  = CSR_OP_RW;
        w_seq_addr   = A_MSTATUS;
        w_seq_wdata  = w_mstatus_mret;
        w_state_next = M_EPC;
      end
      M_EPC: begin
        w_seq_rd     = 1'b1;
        w_seq_addr   = A_MEPC;
        w_state_next = M_DONE;
      end
      M_DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mstatus     <= '0;
      r_trap_target <= '0;
      r_mret_target <= '0;
      r_trap_done   <= 1'b0;
      r_mret_done   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_trap_done <= (w_state_next == T_DONE);
      r_mret_done <= (w_state_next == M_DONE);
      if (r_state == T_ST_RD || r_state == M_ST_RD) begin
        r_mstatus <= csr_rdata;
      end
      if (r_state == T_VEC) begin
        r_trap_target <= w_trap_target;
      end
      if (r_state == M_EPC) begin
        r_mret_target <= csr_rdata;
      end
    end
  end

  csr_port_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_mux (
    .i_sel_pipe   (w_sel_pipe),
    .i_pipe_rd    (pipe_csr_rd),
    .i_pipe_wr_op (pipe_csr_wr_op),
    .i_pipe_addr  (pipe_csr_addr),
    .i_pipe_wdata (pipe_csr_wdata),
    .i_seq_rd     (w_seq_rd),
    .i_seq_wr_op  (w_seq_wr_op),
    .i_seq_addr   (w_seq_addr),
    .i_seq_wdata  (w_seq_wdata),
    .o_csr_rd     (csr_rd),
    .o_csr_wr_op  (csr_wr_op),
    .o_csr_addr   (csr_addr),
    .o_csr_wdata  (csr_wdata)
  );

  assign pipe_stall  = w_stall;
  assign trap_done   = r_trap_done;
  assign mret_done   = r_mret_done;
  assign trap_target = r_trap_target;
  assign mret_target = r_mret_target;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Bench for csr_trap_seq: a CSR file model behind the shared port, directed
// trap/mret/pipeline scenarios, and a scoreboard checking every done pulse.
module tb_csr_trap_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_clr = 1'b1;
  logic        pipe_csr_rd = 1'b0;
  logic [1:0]  pipe_csr_wr_op = 2'd0;
  logic [11:0] pipe_csr_addr = 12'h0;
  logic [31:0] pipe_csr_wdata = 32'h0;
  logic        pipe_stall;
  logic        trap_req = 1'b0;
  logic [31:0] trap_cause = 32'h0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] trap_tval = 32'h0;
  logic        mret_req = 1'b0;
  logic        trap_done;
  logic [31:0] trap_target;
  logic        mret_done;
  logic [31:0] mret_target;
  logic        csr_rd;
  logic [1:0]  csr_wr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  logic [31:0] csr_mem [0:4095];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_mret;
    logic [31:0] target;
    int          start;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  csr_trap_seq #(.DATA_W(32), .ADDR_W(12)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_csr_rd    (pipe_csr_rd),
    .pipe_csr_wr_op (pipe_csr_wr_op),
    .pipe_csr_addr  (pipe_csr_addr),
    .pipe_csr_wdata (pipe_csr_wdata),
    .pipe_stall     (pipe_stall),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .mret_req       (mret_req),
    .trap_done      (trap_done),
    .trap_target    (trap_target),
    .mret_done      (mret_done),
    .mret_target    (mret_target),
    .csr_rd         (csr_rd),
    .csr_wr_op      (csr_wr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CSR file: combinational read, RW/RS/RC writes on the clock edge.
  assign csr_rdata = csr_mem[csr_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
    end else begin
      case (csr_wr_op)
        2'd1: csr_mem[csr_addr] <= csr_wdata;
        2'd2: csr_mem[csr_addr] <= csr_mem[csr_addr] | csr_wdata;
        2'd3: csr_mem[csr_addr] <= csr_mem[csr_addr] & ~csr_wdata;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitor: each done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (trap_done || mret_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'({trap_done, mret_done}), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.is_mret ? "mret_pulse" : "trap_pulse",
              64'({trap_done, mret_done}), e.is_mret ? 64'd1 : 64'd2);
        check(e.is_mret ? "mret_target" : "trap_target",
              64'(e.is_mret ? mret_target : trap_target), 64'(e.target));
        check(e.is_mret ? "mret_latency" : "trap_latency",
              64'(cyc - e.start), 64'(e.lat));
      end
    end
  end

  function automatic logic [47:0] trace_exp(input int c, input logic [31:0] pc,
                                            input logic [31:0] cause, input logic [31:0] tval,
                                            input logic [31:0] mst);
    case (c)
      1: trace_exp = {1'b1, 1'b0, 2'd1, 12'h341, pc};
      2: trace_exp = {1'b1, 1'b0, 2'd1, 12'h342, cause};
      3: trace_exp = {1'b1, 1'b0, 2'd1, 12'h343, tval};
      4: trace_exp = {1'b1, 1'b1, 2'd0, 12'h300, 32'h0};
      5: trace_exp = {1'b1, 1'b0, 2'd1, 12'h300, mst};
      6: trace_exp = {1'b1, 1'b1, 2'd0, 12'h305, 32'h0};
      default: trace_exp = {1'b1, 1'b0, 2'd0, 12'h000, 32'h0};
    endcase
  endfunction

  task automatic pipe_wr(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    pipe_csr_wr_op = 2'd1;
    pipe_csr_addr  = addr;
    pipe_csr_wdata = data;
    @(negedge clk);
    pipe_csr_wr_op = 2'd0;
  endtask

  task automatic run_trap(input logic [31:0] cause, input logic [31:0] pc,
                          input logic [31:0] tval, input logic [31:0] exp_tgt,
                          input bit trace, input logic [31:0] exp_mst);
    bit got;
    logic [47:0] act;
    @(negedge clk);
    trap_cause = cause;
    trap_pc    = pc;
    trap_tval  = tval;
    trap_req   = 1'b1;
    exp_q.push_back('{1'b0, exp_tgt, cyc, 7});
    #1 check("accept_stall", 64'(pipe_stall), 64'd1);
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (trace && c <= 7) begin
        act = {pipe_stall, csr_rd, csr_wr_op, csr_addr, (csr_wr_op != 2'd0) ? csr_wdata : 32'h0};
        check($sformatf("trap_port_c%0d", c), 64'(act),
              64'(trace_exp(c, pc, cause, tval, exp_mst)));
      end
      if (trap_done) got = 1'b1;
    end
    if (!got) check("trap_timeout", 64'd0, 64'd1);
    trap_req = 1'b0;
  endtask

  task automatic run_mret(input logic [31:0] exp_tgt);
    bit got;
    @(negedge clk);
    mret_req = 1'b1;
    exp_q.push_back('{1'b1, exp_tgt, cyc, 4});
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (mret_done) got = 1'b1;
    end
    if (!got) check("mret_timeout", 64'd0, 64'd1);
    mret_req = 1'b0;
  endtask

  logic [31:0] vec_mtvec [5] = '{32'h80000101, 32'h80000101, 32'h80000100, 32'hFFFFFFFD, 32'h00000103};
  logic [31:0] vec_cause [5] = '{32'h80000007, 32'h0000000B, 32'h80000007, 32'h80000003, 32'h80000001};
  logic [31:0] vec_tgt   [5] = '{32'h8000011C, 32'h80000100, 32'h80000100, 32'h00000008, 32'h00000100};

  initial begin
    bit got;
    repeat (2) @(negedge clk);
    check("reset_flags", 64'({trap_done, mret_done, pipe_stall}), 64'd0);
    check("reset_trap_target", 64'(trap_target), 64'd0);
    check("reset_mret_target", 64'(mret_target), 64'd0);
    rst_n   = 1'b1;
    mem_clr = 1'b0;
    @(negedge clk);

    // Idle pipeline RS passes straight through with no stall.
    pipe_csr_rd    = 1'b1;
    pipe_csr_wr_op = 2'd2;
    pipe_csr_addr  = 12'h300;
    pipe_csr_wdata = 32'h8;
    #1 check("idle_passthru", 64'({pipe_stall, csr_rd, csr_wr_op, csr_addr, csr_wdata}),
             64'({1'b0, 1'b1, 2'd2, 12'h300, 32'h8}));
    @(negedge clk);
    pipe_csr_rd    = 1'b0;
    pipe_csr_wr_op = 2'd0;
    check("idle_rs_mstatus", 64'(csr_mem[12'h300]), 64'h8);

    // Basic exception trap with per-cycle port trace.
    pipe_wr(12'h305, 32'h80000100);
    run_trap(32'hB, 32'h1234, 32'h0, 32'h80000100, 1'b1, 32'h1880);
    check("trap_mepc", 64'(csr_mem[12'h341]), 64'h1234);
    check("trap_mcause", 64'(csr_mem[12'h342]), 64'hB);
    check("trap_mtval", 64'(csr_mem[12'h343]), 64'h0);
    check("trap_mstatus", 64'(csr_mem[12'h300]), 64'h1880);

    // mret restores MIE from MPIE.
    run_mret(32'h1234);
    check("mret_mstatus", 64'(csr_mem[12'h300]), 64'h1888);

    // Vector target computation, including wrap-around and non-01 modes.
    for (int i = 0; i < 5; i++) begin
      pipe_wr(12'h305, vec_mtvec[i]);
      run_trap(vec_cause[i], 32'h100 + 32'(i), 32'h0, vec_tgt[i], 1'b0, 32'h0);
    end

    // Trap, mret and a pipeline write in the same cycle.
    pipe_wr(12'h305, 32'h80000100);
    pipe_wr(12'h300, 32'h8);
    @(negedge clk);
    trap_cause     = 32'h2;
    trap_pc        = 32'h5678;
    trap_tval      = 32'h0;
    trap_req       = 1'b1;
    mret_req       = 1'b1;
    pipe_csr_wr_op = 2'd1;
    pipe_csr_addr  = 12'h340;
    pipe_csr_wdata = 32'hDEAD;
    exp_q.push_back('{1'b0, 32'h80000100, cyc, 7});
    exp_q.push_back('{1'b1, 32'h5678, cyc + 8, 4});
    #1 check("collide_port_blocked", 64'({pipe_stall, csr_rd, csr_wr_op}), 64'({1'b1, 1'b0, 2'd0}));
    @(negedge clk);
    pipe_csr_wr_op = 2'd0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (trap_done) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) check("collide_trap_timeout", 64'd0, 64'd1);
    trap_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (mret_done) got = 1'b1;
    end
    if (!got) check("collide_mret_timeout", 64'd0, 64'd1);
    mret_req = 1'b0;
    check("collide_mscratch", 64'(csr_mem[12'h340]), 64'h0);
    check("collide_mstatus", 64'(csr_mem[12'h300]), 64'h1888);
    check("collide_mepc", 64'(csr_mem[12'h341]), 64'h5678);

    // Reset during T_TVAL abandons the sequence but keeps earlier writes.
    pipe_wr(12'h343, 32'hAAAA);
    @(negedge clk);
    trap_cause = 32'h5;
    trap_pc    = 32'h2222;
    trap_tval  = 32'h77;
    trap_req   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_tval", 64'({csr_wr_op, csr_addr}), 64'({2'd1, 12'h343}));
    rst_n    = 1'b0;
    trap_req = 1'b0;
    #1 check("rst_outputs", 64'({trap_done, mret_done, pipe_stall, csr_wr_op}), 64'd0);
    check("rst_trap_target", 64'(trap_target), 64'd0);
    check("rst_mret_target", 64'(mret_target), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_mepc_kept", 64'(csr_mem[12'h341]), 64'h2222);
    check("rst_mcause_kept", 64'(csr_mem[12'h342]), 64'h5);
    check("rst_mtval_unwritten", 64'(csr_mem[12'h343]), 64'hAAAA);
    got = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (trap_done) got = 1'b1;
    end
    check("rst_no_trap_done", 64'(got), 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
